fetch_ref_luma_ld: RTL and testbench

- Upstream loader for the reference-luma ping-pong buffer in the fetch stage.
- Accepts reference luma for one search window from the external-memory read bus, 16 pixels per beat.
- Assembles 96-pixel rows and applies left/right picture-edge padding.
- Drives the per-row write interface (valid/addr/data) and the done pulse consumed by the reference-luma buffer.

---
 rtl/fetch_ref_luma_ld_pkg.sv | 23 ++
 rtl/fetch_ref_luma_ld_if.sv | 28 ++
 rtl/fetch_ref_pad.sv | 24 ++
 rtl/fetch_ref_luma_ld.sv | 93 +++++++++
 tb/tb_fetch_ref_luma_ld.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_ref_luma_ld_pkg.sv
// Shared geometry, row/beat types and FSM encoding for the reference-luma loader.
package fetch_ref_luma_ld_pkg;
    localparam int PIXEL_WIDTH        = 8;
    localparam int BUS_PELS           = 16;
    localparam int FETCH_REF_ROW_PELS = 96;
    localparam int FETCH_REF_ROWS     = 80;
    localparam int FETCH_PAD_PELS     = 16;
    localparam int BEATS_PER_ROW      = FETCH_REF_ROW_PELS / BUS_PELS;
    localparam int BEAT_W             = BUS_PELS * PIXEL_WIDTH;
    localparam int ROW_W              = FETCH_REF_ROW_PELS * PIXEL_WIDTH;

    // Pixel 0 sits at the highest index so it lands in the MSBs.
    typedef logic [BUS_PELS-1:0][PIXEL_WIDTH-1:0]           beat_t;
    typedef logic [FETCH_REF_ROW_PELS-1:0][PIXEL_WIDTH-1:0] row_t;
    typedef logic [6:0] row_addr_t;
    typedef logic [2:0] beat_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/fetch_ref_luma_ld_if.sv
// Control, read-bus and row-write signals between the loader and its neighbours.
interface fetch_ref_luma_ld_if;
    import fetch_ref_luma_ld_pkg::*;

    logic      load_start_i;
    logic      pad_left_i;
    logic      pad_right_i;
    logic      bus_valid_i;
    beat_t     bus_data_i;
    logic      bus_ready_o;
    logic      ext_load_valid_o;
    row_addr_t ext_load_addr_o;
    row_t      ext_load_data_o;
    logic      ext_load_done_o;
    logic      busy_o;

    modport master (
        output load_start_i, pad_left_i, pad_right_i, bus_valid_i, bus_data_i,
        input  bus_ready_o, ext_load_valid_o, ext_load_addr_o, ext_load_data_o,
               ext_load_done_o, busy_o
    );

    modport slave (
        input  load_start_i, pad_left_i, pad_right_i, bus_valid_i, bus_data_i,
        output bus_ready_o, ext_load_valid_o, ext_load_addr_o, ext_load_data_o,
               ext_load_done_o, busy_o
    );
endinterface

// File: rtl/fetch_ref_pad.sv
// Combinational picture-edge padding of one assembled row.
module fetch_ref_pad
    import fetch_ref_luma_ld_pkg::*;
(
    input  row_t row,
    input  logic pad_left,
    input  logic pad_right,
    output row_t padded
);
    // Pixel p lives at index ROW_PELS-1-p, so pixel 16 is index 79 and pixel 79 is index 16.
    localparam int LEFT_SRC  = FETCH_REF_ROW_PELS - 1 - FETCH_PAD_PELS;
    localparam int RIGHT_SRC = FETCH_PAD_PELS;

    for (genvar p = 0; p < FETCH_REF_ROW_PELS; p++) begin : g_pel
        localparam int IDX = FETCH_REF_ROW_PELS - 1 - p;
        if (p < FETCH_PAD_PELS) begin : g_left
            assign padded[IDX] = pad_left ? row[LEFT_SRC] : row[IDX];
        end else if (p >= FETCH_REF_ROW_PELS - FETCH_PAD_PELS) begin : g_right
            assign padded[IDX] = pad_right ? row[RIGHT_SRC] : row[IDX];
        end else begin : g_mid
            assign padded[IDX] = row[IDX];
        end
    end
endmodule

// File: rtl/fetch_ref_luma_ld.sv
// Reference-luma window loader: packs 16-pel bus beats into padded 96-pel rows
// and writes them to the ping-pong buffer, pulsing done after the last row.
module fetch_ref_luma_ld
    import fetch_ref_luma_ld_pkg::*;
(
    input logic                clk,
    input logic                rst,
    fetch_ref_luma_ld_if.slave ld
);
    state_e    state, state_nx;
    beat_cnt_t beat_cnt;
    beat_cnt_t slot;
    row_addr_t row_cnt;
    logic      pad_left, pad_right;
    logic [BEATS_PER_ROW-1:0][BEAT_W-1:0] asm_row;
    row_t      row_full, row_padded;
    logic      out_vld;
    row_addr_t out_addr;
    row_t      out_row;
    logic      done_q;
    logic      start_ok, accept, row_end, win_end;

    // A start landing on the done-pulse cycle is still inside the busy window.
    assign start_ok = (state == ST_IDLE) && ld.load_start_i && !done_q;
    assign accept   = (state == ST_LOAD) && ld.bus_valid_i;
    assign row_end  = accept && (beat_cnt == beat_cnt_t'(BEATS_PER_ROW - 1));
    assign win_end  = row_end && (row_cnt == row_addr_t'(FETCH_REF_ROWS - 1));
    assign slot     = beat_cnt_t'(BEATS_PER_ROW - 1) - beat_cnt;

    // The completing beat bypasses the assembly register so the strobe follows in one cycle.
    assign row_full = {asm_row[BEATS_PER_ROW-1:1], ld.bus_data_i};

    fetch_ref_pad u_pad (
        .row       (row_full),
        .pad_left  (pad_left),
        .pad_right (pad_right),
        .padded    (row_padded)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start_ok) state_nx = ST_LOAD;
            ST_LOAD: if (win_end)  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            row_cnt   <= '0;
            pad_left  <= 1'b0;
            pad_right <= 1'b0;
            asm_row   <= '0;
            out_vld   <= 1'b0;
            out_addr  <= '0;
            out_row   <= '0;
            done_q    <= 1'b0;
        end else begin
            out_vld <= row_end;
            done_q  <= (state == ST_DONE);
            if (start_ok) begin
                pad_left  <= ld.pad_left_i;
                pad_right <= ld.pad_right_i;
                beat_cnt  <= '0;
                row_cnt   <= '0;
            end
            if (accept) begin
                asm_row[slot] <= ld.bus_data_i;
                beat_cnt      <= row_end ? '0 : beat_cnt + 3'd1;
            end
            if (row_end) begin
                row_cnt  <= row_cnt + 7'd1;
                out_addr <= row_cnt;
                out_row  <= row_padded;
            end
        end
    end

    assign ld.bus_ready_o      = (state == ST_LOAD);
    assign ld.ext_load_valid_o = out_vld;
    assign ld.ext_load_addr_o  = out_addr;
    assign ld.ext_load_data_o  = out_row;
    assign ld.ext_load_done_o  = done_q;
    assign ld.busy_o           = (state != ST_IDLE) || done_q;
endmodule

// File: tb/tb_fetch_ref_luma_ld.sv
// Randomized bench for the reference-luma loader against a pixel-array window model.
module tb_fetch_ref_luma_ld;
    import fetch_ref_luma_ld_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ref_luma_ld_if ifc();

    fetch_ref_luma_ld dut (
        .clk (clk),
        .rst (rst),
        .ld  (ifc)
    );

    int errs = 0;
    int checks = 0;
    int n_strobe = 0;
    int n_done = 0;

    logic      e_vld, e_done, e_busy, e_ready;
    logic [6:0] e_addr;
    row_t      e_data;
    logic      cur_pl, cur_pr;
    logic [7:0] win [FETCH_REF_ROWS][FETCH_REF_ROW_PELS];

    task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic row_t exp_row(input int r);
        row_t v;
        logic [7:0] p;
        for (int c = 0; c < 96; c++) begin
            if (cur_pl && c < 16)       p = win[r][16];
            else if (cur_pr && c >= 80) p = win[r][79];
            else                        p = win[r][c];
            v[95-c] = p;
        end
        return v;
    endfunction

    function automatic beat_t beat_of(input int r, input int k);
        beat_t b;
        for (int j = 0; j < 16; j++) b[15-j] = win[r][16*k+j];
        return b;
    endfunction

    // Advance one clock, then compare every output against the expectation for this cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (ifc.ext_load_valid_o === 1'b1) n_strobe++;
        if (ifc.ext_load_done_o === 1'b1)  n_done++;
        chk("valid", ifc.ext_load_valid_o, e_vld);
        if (e_vld) begin
            chk("addr", ifc.ext_load_addr_o, e_addr);
            chk("data", ifc.ext_load_data_o, e_data);
        end
        chk("done", ifc.ext_load_done_o, e_done);
        chk("busy", ifc.busy_o, e_busy);
        chk("ready", ifc.bus_ready_o, e_ready);
        e_vld  = 1'b0;
        e_done = 1'b0;
    endtask

    task automatic run_window(input bit pl, input bit pr, input int mode, input int maxgap,
                              input int restart_row, input int abort_row);
        int g;
        for (int r = 0; r < 80; r++)
            for (int c = 0; c < 96; c++)
                win[r][c] = (mode == 0) ? 8'((r*96 + c) & 255) : 8'($urandom);
        if (pl) win[0][16] = 8'h5A;
        if (pr) win[0][79] = 8'hC3;
        cur_pl = pl;
        cur_pr = pr;
        n_strobe = 0;
        n_done = 0;

        ifc.load_start_i = 1'b1;
        ifc.pad_left_i   = pl;
        ifc.pad_right_i  = pr;
        ifc.bus_valid_i  = 1'b0;
        e_busy  = 1'b1;
        e_ready = 1'b1;
        cyc();
        ifc.load_start_i = 1'b0;
        ifc.pad_left_i   = ~pl;
        ifc.pad_right_i  = ~pr;

        for (int r = 0; r < 80; r++) begin
            for (int k = 0; k < 6; k++) begin
                g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
                repeat (g) begin
                    ifc.bus_valid_i = 1'b0;
                    ifc.bus_data_i  = {4{$urandom()}};
                    cyc();
                end
                if (r == abort_row && k == 3) begin
                    rst = 1'b1;
                    ifc.bus_valid_i = 1'b1;
                    ifc.bus_data_i  = beat_of(r, k);
                    e_busy  = 1'b0;
                    e_ready = 1'b0;
                    cyc();
                    chk("abort_addr", ifc.ext_load_addr_o, 0);
                    chk("abort_data", ifc.ext_load_data_o, 0);
                    rst = 1'b0;
                    ifc.bus_valid_i = 1'b0;
                    repeat (4) cyc();
                    chk("abort_ndone", n_done, 0);
                    return;
                end
                ifc.bus_valid_i = 1'b1;
                ifc.bus_data_i  = beat_of(r, k);
                if (r == restart_row && k == 0) begin
                    ifc.load_start_i = 1'b1;
                    ifc.pad_left_i   = ~pl;
                    ifc.pad_right_i  = ~pr;
                end
                if (k == 5) begin
                    e_vld  = 1'b1;
                    e_addr = 7'(r);
                    e_data = exp_row(r);
                    if (r == 79) e_ready = 1'b0;
                end
                cyc();
                ifc.load_start_i = 1'b0;
            end
        end
        ifc.bus_valid_i = 1'b0;
        e_done = 1'b1;
        cyc();
        e_busy = 1'b0;
        cyc();
        chk("n_strobe", n_strobe, 80);
        chk("n_done", n_done, 1);
    endtask

    initial begin
        rst = 1'b1;
        ifc.load_start_i = 1'b0;
        ifc.pad_left_i   = 1'b0;
        ifc.pad_right_i  = 1'b0;
        ifc.bus_valid_i  = 1'b0;
        ifc.bus_data_i   = '0;
        e_vld = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_ready = 1'b0;
        e_addr = '0; e_data = '0;
        cur_pl = 1'b0; cur_pr = 1'b0;
        repeat (2) cyc();
        chk("rst_addr", ifc.ext_load_addr_o, 0);
        chk("rst_data", ifc.ext_load_data_o, 0);
        rst = 1'b0;
        cyc();

        // Bus traffic while idle must be ignored.
        ifc.bus_valid_i = 1'b1;
        repeat (3) begin
            ifc.bus_data_i = {4{$urandom()}};
            cyc();
        end
        ifc.bus_valid_i = 1'b0;
        cyc();

        run_window(1'b0, 1'b0, 0, 0, -1, -1);
        run_window(1'b0, 1'b0, 0, 3, -1, -1);
        run_window(1'b1, 1'b0, 0, 2, 40, -1);
        run_window(1'b0, 1'b1, 0, 1, -1, -1);
        run_window(1'b1, 1'b1, 1, 3, -1, -1);
        run_window(1'b0, 1'b0, 1, 0, -1, 37);
        run_window(1'b0, 1'b0, 0, 0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
